// File: rtl/mac_port_lookup_pkg.sv
// Shared route-class encodings, MAC field layout and the destination-MAC decode
// used by both the port lookup and the RX path.
package mac_port_lookup_pkg;

   typedef enum logic [1:0] {
      SEEK_LOCAL  = 2'b00,
      SEEK_UPLINK = 2'b01,
      SEEK_BUFFER = 2'b10,
      SEEK_DROP   = 2'b11
   } seek_e;

   localparam int MAC_W        = 48;
   localparam int MAC_HEAD_LSB = 16;
   localparam int MAC_TOR_LSB  = 8;
   localparam int MAC_PORT_LSB = 0;

   localparam logic [31:0] P_MAC_HEAD = 32'h8DBC_5C4A;

   typedef struct packed {
      seek_e      seek;
      logic [2:0] outport;
   } route_t;

   // First matching rule wins: malformed MAC, own ToR, circuit peer, else park in DDR.
   function automatic route_t mac_decode(
      input logic [MAC_W-1:0] mac,
      input logic [31:0]      head_ref,
      input logic [7:0]       my_tor,
      input logic [2:0]       cur_tor,
      input logic [2:0]       uplink_port
   );
      logic [31:0] head;
      logic [7:0]  tor;
      logic [7:0]  port;
      route_t      r;
      head = mac[MAC_HEAD_LSB +: 32];
      tor  = mac[MAC_TOR_LSB  +: 8];
      port = mac[MAC_PORT_LSB +: 8];
      if (head != head_ref || tor > 8'd7 || (port != 8'd1 && port != 8'd2)) begin
         r.seek    = SEEK_DROP;
         r.outport = 3'd0;
      end else if (tor == my_tor) begin
         r.seek    = SEEK_LOCAL;
         r.outport = port[1] ? 3'd1 : 3'd0;
      end else if (tor[2:0] == cur_tor) begin
         r.seek    = SEEK_UPLINK;
         r.outport = uplink_port;
      end else begin
         r.seek    = SEEK_BUFFER;
         r.outport = tor[2:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant of one requester per cycle; search begins at the pointer,
// which moves to one past the winner and stays put when nothing is requested.
module rr_arbiter #(
   parameter  int P_N = 2,
   localparam int IW  = (P_N > 1) ? $clog2(P_N) : 1
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic [P_N-1:0] req_i,
   output logic [P_N-1:0] gnt_o,
   output logic [IW-1:0]  gnt_idx_o,
   output logic           gnt_vld_o
);

   logic [IW-1:0] rr_q, rr_d;

   always_comb begin
      int j;
      j         = 0;
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_vld_o = 1'b0;
      for (int i = 0; i < P_N; i++) begin
         j = int'(rr_q) + i;
         if (j >= P_N) j = j - P_N;
         if (!gnt_vld_o && req_i[j]) begin
            gnt_vld_o = 1'b1;
            gnt_o[j]  = 1'b1;
            gnt_idx_o = IW'(j);
         end
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (gnt_vld_o) rr_d = (gnt_idx_o == IW'(P_N - 1)) ? '0 : gnt_idx_o + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rr_q <= '0;
      else         rr_q <= rr_d;
   end

endmodule

// File: rtl/mac_port_lookup.sv
// Resolves destination MACs from several RX requesters to an output port and route class.
// Two cycles request-to-result; one pending slot per requester, extra requests dropped with sticky overflow.
module mac_port_lookup
   import mac_port_lookup_pkg::*;
#(
   parameter int          P_NUM_REQ     = 2,
   parameter logic [31:0] P_MAC_HEAD    = mac_port_lookup_pkg::P_MAC_HEAD,
   parameter logic [7:0]  P_MY_TOR_ID   = 8'd0,
   parameter logic [2:0]  P_UPLINK_PORT = 3'd2
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [48*P_NUM_REQ-1:0] i_check_mac,
   input  logic [P_NUM_REQ-1:0]    i_check_valid,
   input  logic [2:0]              i_cur_connect_tor,
   output logic [2:0]              o_outport,
   output logic [1:0]              o_seek_flag,
   output logic [3:0]              o_check_id,
   output logic                    o_result_valid,
   output logic                    o_overflow
);

   localparam int IW = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;

   logic [P_NUM_REQ-1:0] pend_q, pend_d;
   logic [MAC_W-1:0]     mac_q [P_NUM_REQ];
   logic [MAC_W-1:0]     mac_d [P_NUM_REQ];
   logic                 ovf_q, ovf_d;

   logic [P_NUM_REQ-1:0] gnt;
   logic [IW-1:0]        gnt_idx;
   logic                 gnt_vld;
   logic [MAC_W-1:0]     gnt_mac;
   route_t               route;

   logic                 result_vld_q;
   logic [2:0]           outport_q;
   logic [1:0]           seek_q;
   logic [3:0]           check_id_q;

   rr_arbiter #(.P_N(P_NUM_REQ)) u_arb (
      .clk_i     (i_clk),
      .rst_ni    (i_rst_n),
      .req_i     (pend_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_vld_o (gnt_vld)
   );

   always_comb begin
      gnt_mac = '0;
      for (int k = 0; k < P_NUM_REQ; k++) begin
         if (gnt[k]) gnt_mac = mac_q[k];
      end
      route = mac_decode(gnt_mac, P_MAC_HEAD, P_MY_TOR_ID, i_cur_connect_tor, P_UPLINK_PORT);
   end

   // A slot being granted this cycle is free to take a new request in the same cycle.
   always_comb begin
      pend_d = pend_q;
      mac_d  = mac_q;
      ovf_d  = ovf_q | (|(i_check_valid & pend_q & ~gnt));
      for (int k = 0; k < P_NUM_REQ; k++) begin
         if (i_check_valid[k] && (!pend_q[k] || gnt[k])) begin
            pend_d[k] = 1'b1;
            mac_d[k]  = i_check_mac[48*k +: 48];
         end else if (gnt[k]) begin
            pend_d[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pend_q       <= '0;
         ovf_q        <= 1'b0;
         result_vld_q <= 1'b0;
         outport_q    <= 3'd0;
         seek_q       <= 2'd0;
         check_id_q   <= 4'd0;
         for (int k = 0; k < P_NUM_REQ; k++) mac_q[k] <= '0;
      end else begin
         pend_q       <= pend_d;
         ovf_q        <= ovf_d;
         mac_q        <= mac_d;
         result_vld_q <= gnt_vld;
         if (gnt_vld) begin
            outport_q  <= route.outport;
            seek_q     <= route.seek;
            check_id_q <= 4'(gnt_idx);
         end
      end
   end

   assign o_outport      = outport_q;
   assign o_seek_flag    = seek_q;
   assign o_check_id     = check_id_q;
   assign o_result_valid = result_vld_q;
   assign o_overflow     = ovf_q;

endmodule

// File: tb/tb_mac_port_lookup.sv
// Bench for mac_port_lookup: directed route/arbitration/overflow/reset scenarios
// plus randomized traffic against a cycle-level behavioural model.
module tb_mac_port_lookup;

   localparam int N = 2;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic [95:0]   i_check_mac;
   logic [1:0]    i_check_valid;
   logic [2:0]    i_cur_connect_tor;
   logic [2:0]    o_outport;
   logic [1:0]    o_seek_flag;
   logic [3:0]    o_check_id;
   logic          o_result_valid;
   logic          o_overflow;

   int total = 0;
   int bad   = 0;

   // behavioural model state
   bit          m_pend [N];
   logic [47:0] m_mac  [N];
   int          m_rr;
   bit          m_ovf;
   logic        exp_vld;
   logic [1:0]  exp_seek;
   logic [2:0]  exp_out;
   logic [3:0]  exp_id;

   mac_port_lookup dut (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .i_check_mac       (i_check_mac),
      .i_check_valid     (i_check_valid),
      .i_cur_connect_tor (i_cur_connect_tor),
      .o_outport         (o_outport),
      .o_seek_flag       (o_seek_flag),
      .o_check_id        (o_check_id),
      .o_result_valid    (o_result_valid),
      .o_overflow        (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [47:0] mk(input logic [31:0] h, input int tor, input int port);
      return {h, 8'(tor), 8'(port)};
   endfunction

   function automatic void ref_route(input logic [47:0] mac, input int cur,
                                     output logic [1:0] s, output logic [2:0] o);
      longint unsigned v, head, tor, port;
      v    = 64'(mac);
      head = v / 65536;
      tor  = (v / 256) % 256;
      port = v % 256;
      if (head != 64'h8DBC5C4A || tor > 7 || !(port == 1 || port == 2)) begin
         s = 2'd3; o = 3'd0;
      end else if (tor == 0) begin
         s = 2'd0; o = 3'(port - 1);
      end else if (tor == longint'(cur)) begin
         s = 2'd1; o = 3'd2;
      end else begin
         s = 2'd2; o = 3'(tor);
      end
   endfunction

   task automatic model_clear();
      for (int k = 0; k < N; k++) begin m_pend[k] = 0; m_mac[k] = '0; end
      m_rr = 0; m_ovf = 0;
      exp_vld = 0; exp_seek = 0; exp_out = 0; exp_id = 0;
   endtask

   task automatic model_step();
      int g;
      g = -1;
      for (int i = 0; i < N; i++) begin
         int j;
         j = (m_rr + i) % N;
         if (g < 0 && m_pend[j]) g = j;
      end
      if (g >= 0) begin
         ref_route(m_mac[g], int'(i_cur_connect_tor), exp_seek, exp_out);
         exp_id  = 4'(g);
         exp_vld = 1;
         m_rr    = (g + 1) % N;
      end else begin
         exp_vld = 0;
      end
      for (int k = 0; k < N; k++) begin
         if (i_check_valid[k]) begin
            if (!m_pend[k] || k == g) begin
               m_pend[k] = 1;
               m_mac[k]  = i_check_mac[48*k +: 48];
            end else begin
               m_ovf = 1;
            end
         end else if (k == g) begin
            m_pend[k] = 0;
         end
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      i_check_valid = '0;
      model_clear();
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (o_result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_result_valid); end
      total++; if (o_outport !== 3'd0) begin bad++; $display("FAIL reset_outport got=%0d want=0", o_outport); end
      total++; if (o_seek_flag !== 2'd0) begin bad++; $display("FAIL reset_seek got=%0d want=0", o_seek_flag); end
      total++; if (o_check_id !== 4'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", o_check_id); end
      total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", o_overflow); end
   endtask

   task automatic test_routes();
      int          rq   [4] = '{0, 1, 0, 0};
      logic [47:0] mac  [4] = '{48'h8DBC5C4A_0002, 48'h8DBC5C4A_0301, 48'h8DBC5C4A_0501, 48'h11223344_0101};
      logic [1:0]  seek [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
      logic [2:0]  outp [4] = '{3'd1, 3'd2, 3'd5, 3'd0};
      i_cur_connect_tor = 3'd3;
      for (int t = 0; t < 4; t++) begin
         i_check_mac[48*rq[t] +: 48] = mac[t];
         i_check_valid = 2'(1 << rq[t]);
         cycle();
         i_check_valid = '0;
         total++; if (o_result_valid !== 1'b0) begin bad++; $display("FAIL route%0d_early valid=%b want=0", t, o_result_valid); end
         cycle();
         total++; if (o_result_valid !== 1'b1) begin bad++; $display("FAIL route%0d_valid got=%b want=1", t, o_result_valid); end
         total++; if (o_seek_flag !== seek[t]) begin bad++; $display("FAIL route%0d_seek got=%0d want=%0d", t, o_seek_flag, seek[t]); end
         total++; if (o_outport !== outp[t]) begin bad++; $display("FAIL route%0d_outport got=%0d want=%0d", t, o_outport, outp[t]); end
         total++; if (o_check_id !== 4'(rq[t])) begin bad++; $display("FAIL route%0d_id got=%0d want=%0d", t, o_check_id, rq[t]); end
         cycle();
         total++; if (o_result_valid !== 1'b0 || o_outport !== outp[t] || o_seek_flag !== seek[t]) begin
            bad++; $display("FAIL route%0d_hold valid=%b out=%0d seek=%0d want 0/%0d/%0d", t, o_result_valid, o_outport, o_seek_flag, outp[t], seek[t]);
         end
      end
   endtask

   task automatic test_contention();
      do_reset();
      i_cur_connect_tor = 3'd3;
      i_check_mac = {mk(32'h8DBC5C4A, 3, 1), mk(32'h8DBC5C4A, 0, 2)};
      i_check_valid = 2'b11;
      cycle();
      i_check_valid = 2'b00;
      cycle();
      total++; if (o_result_valid !== 1'b1 || o_check_id !== 4'd0) begin bad++; $display("FAIL cont_first valid=%b id=%0d want 1/0", o_result_valid, o_check_id); end
      cycle();
      total++; if (o_result_valid !== 1'b1 || o_check_id !== 4'd1) begin bad++; $display("FAIL cont_second valid=%b id=%0d want 1/1", o_result_valid, o_check_id); end
      cycle();
      total++; if (o_result_valid !== 1'b0) begin bad++; $display("FAIL cont_idle valid=%b want=0", o_result_valid); end
      // lone grant to requester 0 moves the pointer to 1
      i_check_valid = 2'b01;
      cycle();
      i_check_valid = 2'b00;
      repeat (3) cycle();
      i_check_valid = 2'b11;
      cycle();
      i_check_valid = 2'b00;
      cycle();
      total++; if (o_result_valid !== 1'b1 || o_check_id !== 4'd1) begin bad++; $display("FAIL cont_rr_first valid=%b id=%0d want 1/1", o_result_valid, o_check_id); end
      total++; if (o_seek_flag !== 2'd1 || o_outport !== 3'd2) begin bad++; $display("FAIL cont_rr_route seek=%0d out=%0d want 1/2", o_seek_flag, o_outport); end
      cycle();
      total++; if (o_result_valid !== 1'b1 || o_check_id !== 4'd0) begin bad++; $display("FAIL cont_rr_second valid=%b id=%0d want 1/0", o_result_valid, o_check_id); end
      cycle();
   endtask

   task automatic test_overflow();
      // pointer is at 1 here, so requester 1 wins the first grant
      i_check_mac = {mk(32'h8DBC5C4A, 6, 1), mk(32'h8DBC5C4A, 0, 2)};
      i_check_valid = 2'b11;
      cycle();
      i_check_mac[47:0] = mk(32'h11223344, 1, 1);
      i_check_valid = 2'b01;
      cycle();
      i_check_valid = 2'b00;
      total++; if (o_result_valid !== 1'b1 || o_check_id !== 4'd1) begin bad++; $display("FAIL ovf_grant1 valid=%b id=%0d want 1/1", o_result_valid, o_check_id); end
      total++; if (o_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", o_overflow); end
      cycle();
      total++; if (o_result_valid !== 1'b1 || o_check_id !== 4'd0 || o_seek_flag !== 2'd0 || o_outport !== 3'd1) begin
         bad++; $display("FAIL ovf_first_mac valid=%b id=%0d seek=%0d out=%0d want 1/0/0/1", o_result_valid, o_check_id, o_seek_flag, o_outport);
      end
      repeat (4) cycle();
      total++; if (o_result_valid !== 1'b0) begin bad++; $display("FAIL ovf_dropped valid=%b want=0", o_result_valid); end
      total++; if (o_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", o_overflow); end
      do_reset();
      total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL ovf_cleared got=%b want=0", o_overflow); end
   endtask

   task automatic test_reset_midflight();
      i_cur_connect_tor = 3'd3;
      i_check_mac[95:48] = mk(32'h8DBC5C4A, 6, 2);
      i_check_valid = 2'b10;
      cycle();
      i_check_valid = 2'b00;
      repeat (2) cycle();
      total++; if (o_outport !== 3'd6 || o_seek_flag !== 2'd2) begin bad++; $display("FAIL mid_pre out=%0d seek=%0d want 6/2", o_outport, o_seek_flag); end
      i_check_mac[47:0] = mk(32'h8DBC5C4A, 0, 1);
      i_check_valid = 2'b01;
      cycle();
      i_check_valid = 2'b00;
      #2;
      i_rst_n = 1'b0;
      model_clear();
      #1;
      total++; if ({o_result_valid, o_outport, o_seek_flag, o_check_id, o_overflow} !== 11'd0) begin
         bad++; $display("FAIL mid_async valid=%b out=%0d seek=%0d id=%0d ovf=%b want all 0", o_result_valid, o_outport, o_seek_flag, o_check_id, o_overflow);
      end
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cycle();
         total++; if ({o_result_valid, o_outport, o_seek_flag, o_check_id, o_overflow} !== 11'd0) begin
            bad++; $display("FAIL mid_after%0d valid=%b out=%0d seek=%0d id=%0d ovf=%b want all 0", c, o_result_valid, o_outport, o_seek_flag, o_check_id, o_overflow);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < N; k++) begin
            logic [31:0] h;
            h = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'h8DBC5C4A;
            i_check_mac[48*k +: 48] = mk(h, int'($urandom_range(0, 9)), int'($urandom_range(0, 3)));
            i_check_valid[k] = ($urandom_range(0, 9) < 4);
         end
         i_cur_connect_tor = 3'($urandom_range(0, 7));
         cycle();
         total++; if (o_result_valid !== exp_vld) begin bad++; $display("FAIL rnd%0d_valid got=%b want=%b", c, o_result_valid, exp_vld); end
         total++; if (o_seek_flag !== exp_seek || o_outport !== exp_out || o_check_id !== exp_id) begin
            bad++; $display("FAIL rnd%0d_result seek=%0d out=%0d id=%0d want %0d/%0d/%0d", c, o_seek_flag, o_outport, o_check_id, exp_seek, exp_out, exp_id);
         end
         total++; if (o_overflow !== m_ovf) begin bad++; $display("FAIL rnd%0d_ovf got=%b want=%b", c, o_overflow, m_ovf); end
      end
      i_check_valid = '0;
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_check_mac = '0;
      i_check_valid = '0;
      i_cur_connect_tor = 3'd0;
      model_clear();
      #3;
      test_reset();
      test_routes();
      test_contention();
      test_overflow();
      test_reset_midflight();
      do_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
